// File: rtl/ped_signal_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ped_signal_ctrl: pedestrian crossing lamp controller slaved to the      |
// | vehicle light sequence, with a debounced request button and a fault flag.|
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module ped_signal_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_TICKS      = 6,
    parameter int CLEAR_TICKS     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [2:0] veh_state,
    input  logic       button,
    output logic       ped_red,
    output logic       ped_green,
    output logic       wait_led,
    output logic [3:0] ped_remaining,
    output logic       fault
);

    localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] WALK_LOAD  = 4'(WALK_TICKS - 1);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_TICKS - 1);
    localparam logic [3:0] CLEAR_LEN  = 4'(CLEAR_TICKS);
    localparam logic [2:0] VEH_RED    = 3'd1;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        STOP  = 2'd1,
        WALK  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [3:0] counter, counter_nx;
    logic       req_pending, req_nx;
    logic       blink, blink_nx;
    logic       fault_q, fault_nx;

    logic       sync1, sync2;
    logic       db_level;
    logic [3:0] db_count;
    logic [2:0] prev_q;

    logic       btn_rise;
    logic       red_entry;
    logic       veh_off;

    // Level flips on the last of DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_count <= 4'd0;
            prev_q   <= 3'd0;
        end else begin
            sync1  <= button;
            sync2  <= sync1;
            prev_q <= veh_state;
            if (sync2 != db_level) begin
                if (db_count == DB_LAST) begin
                    db_level <= sync2;
                    db_count <= 4'd0;
                end else begin
                    db_count <= db_count + 4'd1;
                end
            end else begin
                db_count <= 4'd0;
            end
        end
    end

    assign btn_rise  = !db_level && sync2 && (db_count == DB_LAST);
    assign red_entry = (veh_state == VEH_RED) && (prev_q != VEH_RED);
    assign veh_off   = (veh_state == 3'd0) || (veh_state == 3'd6) || (veh_state == 3'd7);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= OFF;
            counter     <= 4'd0;
            req_pending <= 1'b0;
            blink       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_nx;
            counter     <= counter_nx;
            req_pending <= req_nx;
            blink       <= blink_nx;
            fault_q     <= fault_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        req_nx     = req_pending;
        blink_nx   = blink;
        fault_nx   = fault_q;
        if (veh_off) begin
            state_nx = OFF;
            req_nx   = 1'b0;
            if (state == WALK || state == CLEAR) begin
                fault_nx = 1'b1;
            end
        end else begin
            case (state)
                OFF: state_nx = STOP;
                STOP: begin
                    if (red_entry && req_pending) begin
                        state_nx   = WALK;
                        counter_nx = WALK_LOAD;
                        req_nx     = 1'b0;
                    end else if (btn_rise) begin
                        req_nx = 1'b1;
                    end
                end
                WALK: begin
                    // Vehicles leaving red while pedestrians cross is a safety abort.
                    if (veh_state != VEH_RED) begin
                        state_nx = STOP;
                        fault_nx = 1'b1;
                    end else if (tick) begin
                        if (counter == 4'd0) begin
                            state_nx   = CLEAR;
                            counter_nx = CLEAR_LOAD;
                            blink_nx   = 1'b1;
                        end else begin
                            counter_nx = counter - 4'd1;
                        end
                    end
                end
                CLEAR: begin
                    if (veh_state != VEH_RED) begin
                        state_nx = STOP;
                        fault_nx = 1'b1;
                    end else if (tick) begin
                        blink_nx = ~blink;
                        if (counter == 4'd0) begin
                            state_nx = STOP;
                        end else begin
                            counter_nx = counter - 4'd1;
                        end
                    end
                end
                default: state_nx = OFF;
            endcase
        end
    end

    always_comb begin
        ped_red       = (state == STOP);
        ped_green     = (state == WALK) || ((state == CLEAR) && blink);
        ped_remaining = 4'd0;
        if (state == WALK) begin
            ped_remaining = counter + 4'd1 + CLEAR_LEN;
        end else if (state == CLEAR) begin
            ped_remaining = counter + 4'd1;
        end
    end

    assign wait_led = req_pending;
    assign fault    = fault_q;

endmodule
`default_nettype wire
